food_spawn_ctrl: RTL and testbench
==================================

FOOD_SPAWN_CTRL -- requirements
Module: food_spawn_ctrl

Interface
REQ-001 SHALL have parameter X_MAX, default 38, max legal column.
REQ-002 SHALL have parameter Y_MAX, default 28, max legal row.
REQ-003 SHALL have parameter FALLBACK_X, default 19, column used on timeout.
REQ-004 SHALL have parameter FALLBACK_Y, default 14, row used on timeout.
REQ-005 SHALL have port clk  in  1  the single clock, all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port spawn_req  in  1  request a new food position (level sampled in IDLE).
REQ-008 SHALL have port rand_x  in  6  column from the position generator.
REQ-009 SHALL have port rand_y  in  5  row from the position generator.
REQ-010 SHALL have port occ_query  out  1  occupancy lookup request.
REQ-011 SHALL have ports occ_x  out  6  and occ_y  out  5  candidate under lookup.
REQ-012 SHALL have port occ_ack  in  1  lookup complete, qualifies occ_hit.
REQ-013 SHALL have port occ_hit  in  1  candidate cell occupied by the snake.
REQ-014 SHALL have ports food_x  out  6  and food_y  out  5  current food position.
REQ-015 SHALL have port food_valid  out  1  food position is valid.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port spawn_done  out  1  one-cycle completion pulse.
REQ-018 SHALL have port attempts  out  4  failed-candidate count for the current spawn.
REQ-019 SHALL have port spawn_fail  out  1  one-cycle timeout pulse.

Function
REQ-020 SHALL implement states IDLE, SAMPLE, QUERY, DONE.
REQ-021 IDLE with spawn_req=1 SHALL go to SAMPLE next cycle, clear food_valid, clear attempts.
REQ-022 spawn_req in any state other than IDLE SHALL be ignored, with no queuing.
REQ-023 SAMPLE SHALL latch rand_x/rand_y into the candidate register in one cycle.
REQ-024 In SAMPLE, a candidate with x in 1..X_MAX and y in 1..Y_MAX SHALL go to QUERY; any other candidate SHALL count as a failure and stay in SAMPLE.
REQ-025 QUERY SHALL hold occ_query=1 with stable occ_x/occ_y (the candidate) until occ_ack=1, with no timeout on the ack.
REQ-026 In QUERY, occ_ack=1 with occ_hit=1 SHALL count as a failure and return to SAMPLE; occ_ack=1 with occ_hit=0 SHALL load food_x/food_y from the candidate, set food_valid, and go to DONE.
REQ-027 occ_ack and occ_hit SHALL be ignored outside QUERY.
REQ-028 occ_query SHALL deassert in the cycle after the accepting ack.
REQ-029 DONE SHALL assert spawn_done for exactly one cycle, then go to IDLE.
REQ-030 Each failure SHALL increment attempts, saturating at 15.
REQ-031 Best-case latency SHALL be 4 cycles from accepted spawn_req to spawn_done (SAMPLE, QUERY with same-cycle ack, DONE).
REQ-032 food_x/food_y/food_valid SHALL otherwise hold their values, including while busy.

Reset
REQ-033 reset SHALL force IDLE and zero food_x, food_y, food_valid, occ_query, occ_x, occ_y, spawn_done, spawn_fail, attempts and busy at the next edge.
REQ-034 reset mid-spawn SHALL abort the spawn without issuing spawn_done, and SHALL drop occ_query.
REQ-035 reset SHALL take priority over spawn_req and occ_ack in the same cycle.

Configuration
REQ-036 Macro SPAWN_TIMEOUT_EN defined: a failure while attempts==15 SHALL load food_x=FALLBACK_X and food_y=FALLBACK_Y, set food_valid, go to DONE, and pulse spawn_fail together with spawn_done.
REQ-037 Macro SPAWN_TIMEOUT_EN undefined: the block SHALL retry indefinitely, and spawn_fail SHALL be constant 0.

Verification
REQ-038 Reset, then spawn_req with rand=(5,7) and occ_ack=1/occ_hit=0 same cycle -> spawn_done 4 cycles later, food=(5,7), food_valid=1, attempts=0.
REQ-039 rand=(0,3), then (39,3), then (10,12) with no hit -> attempts=2, food=(10,12).
REQ-040 First query hit=1 at (8,8), second query (9,8) hit=0 with occ_ack delayed 3 cycles -> occ_query held 4 cycles with occ_x=9 stable, food=(9,8), attempts=1.
REQ-041 spawn_req pulsed while busy -> exactly one spawn_done; reset asserted in QUERY -> no spawn_done, all outputs 0 next cycle.
REQ-042 SPAWN_TIMEOUT_EN defined, occ_hit=1 always -> after 16 failures food=(19,14) and spawn_fail=spawn_done=1 for one cycle; SPAWN_TIMEOUT_EN undefined -> attempts=15, busy stays 1, spawn_fail=0.

Source files
------------

// File: rtl/food_spawn_ctrl.sv
// Food placement FSM: samples random cells until a legal, unoccupied one is found; 4 cycles best case,
// stalls indefinitely on occ_ack. Build with SPAWN_TIMEOUT_EN for fallback placement after 16 failures.
module food_spawn_ctrl #(
   parameter int unsigned X_MAX      = 38,
   parameter int unsigned Y_MAX      = 28,
   parameter int unsigned FALLBACK_X = 19,
   parameter int unsigned FALLBACK_Y = 14
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spawn_req,
   input  logic [5:0] rand_x,
   input  logic [4:0] rand_y,
   output logic       occ_query,
   output logic [5:0] occ_x,
   output logic [4:0] occ_y,
   input  logic       occ_ack,
   input  logic       occ_hit,
   output logic [5:0] food_x,
   output logic [4:0] food_y,
   output logic       food_valid,
   output logic       busy,
   output logic       spawn_done,
   output logic [3:0] attempts,
   output logic       spawn_fail
);

   typedef enum logic [1:0] {IDLE, SAMPLE, QUERY, DONE} state_t;

   localparam logic [5:0] X_LIM = 6'(X_MAX);
   localparam logic [4:0] Y_LIM = 5'(Y_MAX);
`ifdef SPAWN_TIMEOUT_EN
   localparam logic [5:0] FB_X  = 6'(FALLBACK_X);
   localparam logic [4:0] FB_Y  = 5'(FALLBACK_Y);
`endif

   state_t     state, state_nx;
   logic       occ_query_nx;
   logic [5:0] occ_x_nx, food_x_nx;
   logic [4:0] occ_y_nx, food_y_nx;
   logic       food_valid_nx, spawn_done_nx, spawn_fail_nx;
   logic [3:0] attempts_nx;
   logic       cand_ok, failure;

   assign cand_ok = (rand_x != 6'd0) && (rand_x <= X_LIM) &&
                    (rand_y != 5'd0) && (rand_y <= Y_LIM);
   assign busy    = (state != IDLE);

   always_comb begin
      state_nx      = state;
      occ_query_nx  = occ_query;
      occ_x_nx      = occ_x;
      occ_y_nx      = occ_y;
      food_x_nx     = food_x;
      food_y_nx     = food_y;
      food_valid_nx = food_valid;
      attempts_nx   = attempts;
      spawn_done_nx = 1'b0;
      spawn_fail_nx = 1'b0;
      failure       = 1'b0;

      case (state)
         IDLE: begin
            if (spawn_req) begin
               state_nx      = SAMPLE;
               food_valid_nx = 1'b0;
               attempts_nx   = 4'd0;
            end
         end
         SAMPLE: begin
            occ_x_nx = rand_x;
            occ_y_nx = rand_y;
            if (cand_ok) begin
               state_nx     = QUERY;
               occ_query_nx = 1'b1;
            end else begin
               failure = 1'b1;
            end
         end
         QUERY: begin
            if (occ_ack) begin
               occ_query_nx = 1'b0;
               if (occ_hit) begin
                  failure  = 1'b1;
                  state_nx = SAMPLE;
               end else begin
                  food_x_nx     = occ_x;
                  food_y_nx     = occ_y;
                  food_valid_nx = 1'b1;
                  spawn_done_nx = 1'b1;
                  state_nx      = DONE;
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      // Failures either bump the saturating count or, once it is full, force the fallback cell.
      if (failure) begin
`ifdef SPAWN_TIMEOUT_EN
         if (attempts == 4'd15) begin
            food_x_nx     = FB_X;
            food_y_nx     = FB_Y;
            food_valid_nx = 1'b1;
            spawn_done_nx = 1'b1;
            spawn_fail_nx = 1'b1;
            state_nx      = DONE;
         end else begin
            attempts_nx = attempts + 4'd1;
         end
`else
         if (attempts != 4'd15)
            attempts_nx = attempts + 4'd1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         occ_query  <= 1'b0;
         occ_x      <= 6'd0;
         occ_y      <= 5'd0;
         food_x     <= 6'd0;
         food_y     <= 5'd0;
         food_valid <= 1'b0;
         attempts   <= 4'd0;
         spawn_done <= 1'b0;
         spawn_fail <= 1'b0;
      end else begin
         state      <= state_nx;
         occ_query  <= occ_query_nx;
         occ_x      <= occ_x_nx;
         occ_y      <= occ_y_nx;
         food_x     <= food_x_nx;
         food_y     <= food_y_nx;
         food_valid <= food_valid_nx;
         attempts   <= attempts_nx;
         spawn_done <= spawn_done_nx;
         spawn_fail <= spawn_fail_nx;
      end
   end

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Bench for food_spawn_ctrl: bench drives generator and occupancy responder, model tracks expected outcome.
module tb_food_spawn_ctrl;

   logic       clk;
   logic       reset;
   logic       spawn_req;
   logic [5:0] rand_x;
   logic [4:0] rand_y;
   logic       occ_query;
   logic [5:0] occ_x;
   logic [4:0] occ_y;
   logic       occ_ack;
   logic       occ_hit;
   logic [5:0] food_x;
   logic [4:0] food_y;
   logic       food_valid;
   logic       busy;
   logic       spawn_done;
   logic [3:0] attempts;
   logic       spawn_fail;

   food_spawn_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .spawn_req  (spawn_req),
      .rand_x     (rand_x),
      .rand_y     (rand_y),
      .occ_query  (occ_query),
      .occ_x      (occ_x),
      .occ_y      (occ_y),
      .occ_ack    (occ_ack),
      .occ_hit    (occ_hit),
      .food_x     (food_x),
      .food_y     (food_y),
      .food_valid (food_valid),
      .busy       (busy),
      .spawn_done (spawn_done),
      .attempts   (attempts),
      .spawn_fail (spawn_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int errs  = 0;

   // Candidate script for one spawn: position, whether the snake occupies it, ack delay.
   logic [5:0] cx [40];
   logic [4:0] cy [40];
   bit         ch [40];
   int         cd [40];

   // Expected food register contents.
   int exp_fx = 0;
   int exp_fy = 0;
   int exp_fv = 0;

   task automatic chk(input string tag, input int obs, input int want);
      tests++;
      assert (obs === want)
      else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit in_range(input int x, input int y);
      return (x >= 1) && (x <= 38) && (y >= 1) && (y <= 28);
   endfunction

   function automatic int sat15(input int n);
      return (n > 15) ? 15 : n;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_occ_query"},  int'(occ_query),  0);
      chk({tag, "_occ_x"},      int'(occ_x),      0);
      chk({tag, "_occ_y"},      int'(occ_y),      0);
      chk({tag, "_food_x"},     int'(food_x),     0);
      chk({tag, "_food_y"},     int'(food_y),     0);
      chk({tag, "_food_valid"}, int'(food_valid), 0);
      chk({tag, "_busy"},       int'(busy),       0);
      chk({tag, "_spawn_done"}, int'(spawn_done), 0);
      chk({tag, "_spawn_fail"}, int'(spawn_fail), 0);
      chk({tag, "_attempts"},   int'(attempts),   0);
   endtask

   task automatic run_spawn(input int n, input bit noise, output bit finished);
      int nfail = 0;
      bit done = 0;
      int want_fail = 0;
      finished = 0;
      spawn_req = 1'b1;
      step();
      spawn_req = 1'b0;
      exp_fv = 0;
      chk("accept_busy",     int'(busy),       1);
      chk("accept_valid",    int'(food_valid), 0);
      chk("accept_attempts", int'(attempts),   0);
      for (int i = 0; i < n && !done; i++) begin
         bit fail_now;
         rand_x = cx[i];
         rand_y = cy[i];
         if (noise) begin
            spawn_req = 1'($urandom);
            occ_ack   = 1'($urandom);
            occ_hit   = 1'($urandom);
         end
         step();
         spawn_req = 1'b0; occ_ack = 1'b0; occ_hit = 1'b0;
         fail_now = !in_range(int'(cx[i]), int'(cy[i]));
         if (!fail_now) begin
            chk("query_req", int'(occ_query), 1);
            chk("query_x",   int'(occ_x), int'(cx[i]));
            chk("query_y",   int'(occ_y), int'(cy[i]));
            for (int d = 0; d < cd[i]; d++) begin
               rand_x = 6'($urandom);
               rand_y = 5'($urandom);
               if (noise) begin
                  spawn_req = 1'($urandom);
                  occ_hit   = 1'($urandom);
               end
               step();
               spawn_req = 1'b0; occ_hit = 1'b0;
               chk("hold_req",  int'(occ_query),  1);
               chk("hold_x",    int'(occ_x),      int'(cx[i]));
               chk("hold_y",    int'(occ_y),      int'(cy[i]));
               chk("hold_done", int'(spawn_done), 0);
            end
            occ_ack = 1'b1;
            occ_hit = ch[i];
            step();
            occ_ack = 1'b0; occ_hit = 1'b0;
            chk("query_drop", int'(occ_query), 0);
            if (ch[i]) fail_now = 1;
            else begin
               exp_fx = int'(cx[i]); exp_fy = int'(cy[i]); exp_fv = 1;
               done = 1;
            end
         end
         if (fail_now) begin
            nfail++;
`ifdef SPAWN_TIMEOUT_EN
            if (nfail == 16) begin
               exp_fx = 19; exp_fy = 14; exp_fv = 1;
               want_fail = 1;
               done = 1;
            end
`endif
         end
         if (!done) begin
            chk("mid_done",     int'(spawn_done), 0);
            chk("mid_fail",     int'(spawn_fail), 0);
            chk("mid_busy",     int'(busy),       1);
            chk("mid_attempts", int'(attempts),   sat15(nfail));
            chk("mid_valid",    int'(food_valid), 0);
            chk("mid_food_x",   int'(food_x),     exp_fx);
            chk("mid_food_y",   int'(food_y),     exp_fy);
         end
      end
      if (done) begin
         chk("done_pulse",    int'(spawn_done), 1);
         chk("done_fail",     int'(spawn_fail), want_fail);
         chk("done_food_x",   int'(food_x),     exp_fx);
         chk("done_food_y",   int'(food_y),     exp_fy);
         chk("done_valid",    int'(food_valid), exp_fv);
         chk("done_attempts", int'(attempts),   sat15(nfail));
         step();
         chk("after_done",  int'(spawn_done), 0);
         chk("after_fail",  int'(spawn_fail), 0);
         chk("after_busy",  int'(busy),       0);
         chk("after_valid", int'(food_valid), 1);
         chk("after_food_x", int'(food_x),    exp_fx);
         step();
         chk("idle_busy", int'(busy),       0);
         chk("idle_done", int'(spawn_done), 0);
         finished = 1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      bit fin;
      reset = 1'b1; spawn_req = 1'b1; occ_ack = 1'b1; occ_hit = 1'b0;
      rand_x = 6'd5; rand_y = 5'd7;
      step();
      step();
      chk_zero("reset");
      reset = 1'b0; spawn_req = 1'b0; occ_ack = 1'b0;
      step();
      chk("reset_release_busy", int'(busy), 0);

      // Best case: one legal free cell, ack in the first query cycle.
      cx[0] = 6'd5; cy[0] = 5'd7; ch[0] = 0; cd[0] = 0;
      run_spawn(1, 0, fin);
      chk("best_finished", int'(fin), 1);

      // Out-of-range candidates on both column edges, then a good one.
      cx[0] = 6'd0;  cy[0] = 5'd3;  ch[0] = 0; cd[0] = 0;
      cx[1] = 6'd39; cy[1] = 5'd3;  ch[1] = 0; cd[1] = 0;
      cx[2] = 6'd10; cy[2] = 5'd12; ch[2] = 0; cd[2] = 0;
      run_spawn(3, 0, fin);
      chk("range_finished", int'(fin), 1);

      // Occupied cell, then a free cell with a slow ack.
      cx[0] = 6'd8; cy[0] = 5'd8; ch[0] = 1; cd[0] = 0;
      cx[1] = 6'd9; cy[1] = 5'd8; ch[1] = 0; cd[1] = 3;
      run_spawn(2, 0, fin);
      chk("hit_finished", int'(fin), 1);

      // Randomized spawns with noise on ignored inputs.
      for (int s = 0; s < 24; s++) begin
         int n;
         n = int'($urandom_range(1, 8));
         for (int i = 0; i < n - 1; i++) begin
            cx[i] = 6'($urandom_range(0, 45));
            cy[i] = 5'($urandom_range(0, 31));
            ch[i] = ($urandom_range(0, 2) == 0);
            cd[i] = int'($urandom_range(0, 3));
         end
         cx[n-1] = 6'($urandom_range(1, 38));
         cy[n-1] = 5'($urandom_range(1, 28));
         ch[n-1] = 0;
         cd[n-1] = int'($urandom_range(0, 3));
         run_spawn(n, 1, fin);
         chk("rand_finished", int'(fin), 1);
      end

      // Reset while a query is outstanding, with competing request and ack.
      spawn_req = 1'b1;
      step();
      spawn_req = 1'b0;
      rand_x = 6'd12; rand_y = 5'd6;
      step();
      chk("abort_query", int'(occ_query), 1);
      reset = 1'b1; spawn_req = 1'b1; occ_ack = 1'b1; occ_hit = 1'b0;
      step();
      reset = 1'b0; spawn_req = 1'b0; occ_ack = 1'b0;
      exp_fx = 0; exp_fy = 0; exp_fv = 0;
      chk_zero("abort");
      step();
      chk("abort_no_done", int'(spawn_done), 0);
      chk("abort_idle",    int'(busy),       0);

      // Every query hits.
      for (int i = 0; i < 20; i++) begin
         cx[i] = 6'd3; cy[i] = 5'd3; ch[i] = 1; cd[i] = 0;
      end
      run_spawn(20, 0, fin);
`ifdef SPAWN_TIMEOUT_EN
      chk("timeout_finished", int'(fin), 1);
`else
      chk("retry_finished", int'(fin), 0);
      chk("retry_busy",     int'(busy),       1);
      chk("retry_attempts", int'(attempts),   15);
      chk("retry_fail",     int'(spawn_fail), 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_fx = 0; exp_fy = 0; exp_fv = 0;
      chk_zero("retry_reset");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

endmodule
